port_frame_packer: RTL and testbench

Upstream feeder for the parametric barrel shifter. It accepts a stream of single-port words (WIDTH bits) over a valid/ready handshake and packs PORT consecutive words into one WIDTH*PORT frame. Each frame is presented together with its per-frame rotation select to the shifter's data_in/select inputs. The block is double-buffered (assembly buffer plus output register), so input streaming continues while a completed frame waits on the consumer.

---
 rtl/port_frame_packer.sv | 105 ++++++++++
 tb/tb_port_frame_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : port_frame_packer
// Description : Packs PORT consecutive WIDTH-bit words into one frame with a
//               per-frame rotation select. An assembly buffer and an output
//               register are double-buffered. Optional macro PACKER_FLUSH_EN
//               adds a flush input that closes a partial frame early.
// Revision    : 1.0 - initial release
// ============================================================================
module port_frame_packer #(
    parameter int WIDTH     = 64,
    parameter int PORT      = 8,
    parameter int SEL_WIDTH = $clog2(PORT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_WIDTH-1:0]    in_rot,
`ifdef PACKER_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [WIDTH*PORT-1:0]   out_data,
    output logic [SEL_WIDTH-1:0]    out_select,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_WIDTH-1:0]    word_idx
);

    logic [WIDTH*PORT-1:0] r_asm;
    logic                  r_asm_full;
    logic [SEL_WIDTH-1:0]  r_rot;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_close;
    logic                  w_full_next;
    logic                  w_xfer;
    logic [WIDTH*PORT-1:0] w_asm_next;
    logic [SEL_WIDTH-1:0]  w_rot_next;

    assign in_ready = !r_asm_full;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (word_idx == SEL_WIDTH'(PORT - 1));

`ifdef PACKER_FLUSH_EN
    // A flush only closes a frame that holds at least one word.
    assign w_close = (w_accept && w_last) ||
                     (flush && in_ready && ((word_idx != '0) || w_accept));
`else
    assign w_close = w_accept && w_last;
`endif

    // The completing word can go straight to the output register, so a full
    // assembly buffer is only ever registered when the output is blocked.
    assign w_full_next = r_asm_full || w_close;
    assign w_xfer      = w_full_next && (!out_valid || out_ready);
    assign w_rot_next  = (w_accept && (word_idx == '0)) ? in_rot : r_rot;

    always_comb begin
        w_asm_next = r_asm;
        for (int i = 0; i < PORT; i++) begin
            if (w_accept && (word_idx == SEL_WIDTH'(i))) begin
                w_asm_next[i*WIDTH +: WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm      <= '0;
            r_asm_full <= 1'b0;
            r_rot      <= '0;
            word_idx   <= '0;
            out_data   <= '0;
            out_select <= '0;
            out_valid  <= 1'b0;
        end else begin
            r_rot <= w_rot_next;

            if (w_xfer) begin
                out_data   <= w_asm_next;
                out_select <= w_rot_next;
                out_valid  <= 1'b1;
                r_asm      <= '0;
                r_asm_full <= 1'b0;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                r_asm      <= w_asm_next;
                r_asm_full <= w_full_next;
            end

            if (w_close) begin
                word_idx <= '0;
            end else if (w_accept) begin
                word_idx <= word_idx + SEL_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_port_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_frame_packer
// Description : Directed and randomized self-checking bench for the packer
//               (WIDTH=8, PORT=4) against a queue-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_frame_packer;

    localparam int WIDTH = 8;
    localparam int PORT  = 4;
    localparam int SW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [SW-1:0]         in_rot;
`ifdef PACKER_FLUSH_EN
    logic                  flush;
`endif
    logic [WIDTH*PORT-1:0] out_data;
    logic [SW-1:0]         out_select;
    logic                  out_valid;
    logic                  out_ready;
    logic [SW-1:0]         word_idx;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [WIDTH*PORT-1:0] data;
        logic [SW-1:0]         sel;
    } frame_t;

    port_frame_packer #(.WIDTH(WIDTH), .PORT(PORT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rot     (in_rot),
`ifdef PACKER_FLUSH_EN
        .flush      (flush),
`endif
        .out_data   (out_data),
        .out_select (out_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_idx   (word_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rot    = '0;
        out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
        flush     = 1'b0;
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_word(input logic [WIDTH-1:0] d, input logic [SW-1:0] r);
        in_valid = 1'b1;
        in_data  = d;
        in_rot   = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rot = '0; out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (out_select !== '0) begin n_fail++; $display("FAIL reset_out_select: got %h expected 0", out_select); end
        n_checks++; if (word_idx !== '0) begin n_fail++; $display("FAIL reset_word_idx: got %h expected 0", word_idx); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        do_reset();
        out_ready = 1'b1;
        drive_word(8'h11, 2'd2);
        drive_word(8'h22, 2'd0);
        drive_word(8'h33, 2'd0);
        drive_word(8'h44, 2'd0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'h44332211) begin n_fail++; $display("FAIL single_data: got %h expected 44332211", out_data); end
        n_checks++; if (out_select !== 2'd2) begin n_fail++; $display("FAIL single_select: got %0d expected 2", out_select); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            drive_word(WIDTH'(i), 2'd1);
            if (i == 4) begin
                n_checks++; if (out_data !== 32'h04030201 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_frame0: got %h/%b expected 04030201/1", out_data, out_valid); end
            end
        end
        n_checks++; if (out_data !== 32'h08070605 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_frame1: got %h/%b expected 08070605/1", out_data, out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) drive_word(WIDTH'(i), 2'd0);
        out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) drive_word(WIDTH'(i), 2'd3);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        in_valid = 1'b1;
        in_data  = 8'h09;
        repeat (2) tick();
        n_checks++; if (out_data !== 32'h04030201 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %h/%b expected 04030201/1", out_data, out_valid); end
        n_checks++; if (in_ready !== 1'b0 || word_idx !== 2'd0) begin n_fail++; $display("FAIL bp_stall: got rdy=%b idx=%0d expected rdy=0 idx=0", in_ready, word_idx); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_data !== 32'h08070605 || out_select !== 2'd3) begin n_fail++; $display("FAIL bp_release: got %h/%0d expected 08070605/3", out_data, out_select); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (word_idx !== 2'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_resume: got idx=%0d vld=%b expected idx=1 vld=0", word_idx, out_valid); end
    endtask

    task automatic test_rot_ignore();
        do_reset();
        out_ready = 1'b1;
        drive_word(8'hC0, 2'd1);
        drive_word(8'hC1, 2'd3);
        drive_word(8'hC2, 2'd3);
        drive_word(8'hC3, 2'd3);
        n_checks++; if (out_select !== 2'd1 || out_data !== 32'hC3C2C1C0) begin n_fail++; $display("FAIL rot_ignore: got %0d/%h expected 1/C3C2C1C0", out_select, out_data); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        out_ready = 1'b1;
        drive_word(8'h11, 2'd2);
        drive_word(8'h22, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (word_idx !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_select !== '0) begin n_fail++; $display("FAIL midrst_outputs: got idx=%0d vld=%b data=%h sel=%0d expected all 0", word_idx, out_valid, out_data, out_select); end
        tick();
        rst_n = 1'b1;
        tick();
        drive_word(8'hA0, 2'd1);
        drive_word(8'hA1, 2'd0);
        drive_word(8'hA2, 2'd0);
        drive_word(8'hA3, 2'd0);
        n_checks++; if (out_data !== 32'hA3A2A1A0 || out_select !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_frame: got %h/%0d/%b expected A3A2A1A0/1/1", out_data, out_select, out_valid); end
    endtask

`ifdef PACKER_FLUSH_EN
    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        drive_word(8'h55, 2'd2);
        drive_word(8'h66, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (out_data !== 32'h00006655 || out_valid !== 1'b1 || out_select !== 2'd2) begin n_fail++; $display("FAIL flush_partial: got %h/%b/%0d expected 00006655/1/2", out_data, out_valid, out_select); end
        n_checks++; if (word_idx !== 2'd0) begin n_fail++; $display("FAIL flush_idx: got %0d expected 0", word_idx); end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle2: got %b expected 0", out_valid); end
        drive_word(8'h77, 2'd1);
        flush = 1'b1;
        drive_word(8'h88, 2'd0);
        flush = 1'b0;
        n_checks++; if (out_data !== 32'h00008877 || out_valid !== 1'b1 || word_idx !== 2'd0) begin n_fail++; $display("FAIL flush_with_word: got %h/%b/%0d expected 00008877/1/0", out_data, out_valid, word_idx); end
    endtask
`endif

    // Model: a queue of completed frames not yet consumed; at most one can sit
    // in the output register and one in the assembly buffer.
    task automatic test_random();
        frame_t                exp_q[$];
        frame_t                f;
        logic [WIDTH*PORT-1:0] part = '0;
        logic [SW-1:0]         prot = '0;
        int                    pcnt = 0;
        int                    nout = 0;
        logic                  e_rdy, e_vld, v, o;
        logic [WIDTH-1:0]      d;
        logic [SW-1:0]         r;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_rdy = (exp_q.size() < 2);
            e_vld = (exp_q.size() > 0);
            n_checks++; if (in_ready !== e_rdy) begin n_fail++; $display("FAIL rand_in_ready@%0d: got %b expected %b", cyc, in_ready, e_rdy); end
            n_checks++; if (out_valid !== e_vld) begin n_fail++; $display("FAIL rand_out_valid@%0d: got %b expected %b", cyc, out_valid, e_vld); end
            n_checks++; if (word_idx !== SW'(pcnt)) begin n_fail++; $display("FAIL rand_word_idx@%0d: got %0d expected %0d", cyc, word_idx, pcnt); end
            if (e_vld) begin
                n_checks++; if (out_data !== exp_q[0].data || out_select !== exp_q[0].sel) begin n_fail++; $display("FAIL rand_frame@%0d: got %h/%0d expected %h/%0d", cyc, out_data, out_select, exp_q[0].data, exp_q[0].sel); end
            end
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 6);
            d = WIDTH'($urandom);
            r = SW'($urandom);
            in_valid  = v;
            in_data   = d;
            in_rot    = r;
            out_ready = o;
            if (e_vld && o) begin
                void'(exp_q.pop_front());
                nout++;
            end
            if (v && e_rdy) begin
                if (pcnt == 0) prot = r;
                part[pcnt*WIDTH +: WIDTH] = d;
                pcnt++;
                if (pcnt == PORT) begin
                    f.data = part;
                    f.sel  = prot;
                    exp_q.push_back(f);
                    part = '0;
                    pcnt = 0;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (nout < 50) begin n_fail++; $display("FAIL rand_progress: got %0d frames expected at least 50", nout); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_rot_ignore();
        test_reset_mid_frame();
`ifdef PACKER_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
